// File: rtl/decode_queue.sv
// decode_queue: decodes up to WIDTH fetched MIPS-subset instructions per cycle
// and enqueues the decoded entries into a DEPTH-entry in-order FIFO that
// dispatch drains from the head, 0..WIDTH entries per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          per-lane instruction valid
//   in_instr          lane i at [32i+31:32i]
//   in_branch_tag     per-lane branch tag (TAG_W bits each)
//   in_macro_start    per-lane macro-op start flag
//   in_macro_end      per-lane macro-op end flag
//   in_ready          bundle accepted when in_valid!=0 && in_ready
//   flush             discard all queued entries and this cycle's bundle
//   out_entry         slot i = i-th oldest entry, (52+TAG_W) bits per slot,
//                     MSB->LSB: operation[6] alu_fn[6] rs_station[3] reg1[5]
//                     reg2[5] target[5] imm[16] has_reg1 has_reg2 has_target
//                     is_noop branch_tag[TAG_W] macro_start macro_end
//   out_valid         out_valid[i] = (count > i)
//   out_pop           number of head entries consumed this cycle
//   occupancy         current entry count
module decode_queue #(
  parameter int WIDTH     = 2,
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 4,
  parameter int DROP_NOOP = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH-1:0]                 in_valid,
  input  logic [32*WIDTH-1:0]              in_instr,
  input  logic [TAG_W*WIDTH-1:0]           in_branch_tag,
  input  logic [WIDTH-1:0]                 in_macro_start,
  input  logic [WIDTH-1:0]                 in_macro_end,
  output logic                             in_ready,
  input  logic                             flush,
  output logic [(52+TAG_W)*WIDTH-1:0]      out_entry,
  output logic [WIDTH-1:0]                 out_valid,
  input  logic [$clog2(WIDTH+1)-1:0]       out_pop,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int EW       = 52 + TAG_W;
  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH+1);
  localparam int KW       = $clog2(WIDTH+1);
  localparam int NOOP_BIT = TAG_W + 2;

  // Decode one instruction into the upper 50 bits of an entry
  // (operation .. is_noop). Unrecognised encodings produce all-zero fields,
  // which makes them no-ops through rs_station==0.
  function automatic logic [49:0] decode(input logic [31:0] ins);
    logic [5:0]  op;
    logic [5:0]  alu;
    logic [2:0]  rs;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  tg;
    logic [15:0] imm;
    logic        h1;
    logic        h2;
    logic        ht;
    logic        nop;
    op  = ins[31:26];
    alu = '0;
    rs  = '0;
    r1  = '0;
    r2  = '0;
    tg  = '0;
    imm = '0;
    h1  = 1'b0;
    h2  = 1'b0;
    ht  = 1'b0;
    case (ins[31:26])
      6'h09: begin rs = 3'd1; r1 = ins[25:21]; tg = ins[20:16]; imm = ins[15:0]; h1 = 1'b1; ht = 1'b1; end
      6'h0C: begin rs = 3'd1; alu = 6'd2; r1 = ins[25:21]; tg = ins[20:16]; imm = ins[15:0]; h1 = 1'b1; ht = 1'b1; end
      6'h04: begin rs = 3'd3; alu = 6'd3; r1 = ins[25:21]; r2 = ins[20:16]; imm = ins[15:0]; h1 = 1'b1; h2 = 1'b1; end
      6'h23: begin rs = 3'd4; r1 = ins[25:21]; tg = ins[20:16]; imm = ins[15:0]; h1 = 1'b1; ht = 1'b1; end
      6'h2B: begin rs = 3'd4; alu = 6'd1; r1 = ins[25:21]; r2 = ins[20:16]; imm = ins[15:0]; h1 = 1'b1; h2 = 1'b1; end
      6'h0F: begin rs = 3'd3; tg = ins[20:16]; imm = ins[15:0]; ht = 1'b1; end
      6'h00: begin
        case (ins[5:0])
          6'h21: begin rs = 3'd1; r1 = ins[25:21]; r2 = ins[20:16]; tg = ins[15:11]; h1 = 1'b1; h2 = 1'b1; ht = 1'b1; end
          6'h24: begin rs = 3'd1; alu = 6'd1; r1 = ins[25:21]; r2 = ins[20:16]; tg = ins[15:11]; h1 = 1'b1; h2 = 1'b1; ht = 1'b1; end
          6'h1A: begin rs = 3'd2; r1 = ins[25:21]; r2 = ins[20:16]; h1 = 1'b1; h2 = 1'b1; end
          6'h10: begin rs = 3'd2; alu = 6'd1; tg = ins[15:11]; ht = 1'b1; end
          6'h12: begin rs = 3'd2; alu = 6'd2; tg = ins[15:11]; ht = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Unknown encodings carry no opcode either.
    if (rs == 3'd0) op = '0;
    nop = (rs == 3'd0) || (ht && (tg == 5'd0));
    return {op, alu, rs, r1, r2, tg, imm, h1, h2, ht, nop};
  endfunction

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [EW-1:0] w_dec  [WIDTH];
  logic [KW-1:0] w_off  [WIDTH];
  logic [WIDTH-1:0] w_keep;
  logic [KW-1:0] w_k;
  logic          w_ready;
  logic          w_accept;
  logic [CW-1:0] w_pop;

  // Decode every lane and compact the surviving lanes: w_off[i] is lane i's
  // position among the kept lanes, w_k the number kept.
  always_comb begin
    w_k    = '0;
    w_keep = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dec[i]  = {decode(in_instr[32*i +: 32]), in_branch_tag[TAG_W*i +: TAG_W],
                   in_macro_start[i], in_macro_end[i]};
      w_off[i]  = w_k;
      w_keep[i] = in_valid[i] && !((DROP_NOOP != 0) && w_dec[i][NOOP_BIT]);
      if (w_keep[i]) w_k = w_k + KW'(1);
    end
  end

  // Free space is judged on the registered count; pops this cycle do not help.
  assign w_ready  = !flush && ((CW'(DEPTH) - r_count) >= CW'(WIDTH));
  assign w_accept = w_ready && (in_valid != '0);
  // Over-popping is a protocol error; clamp so the count never underflows.
  assign w_pop    = (CW'(out_pop) > r_count) ? r_count : CW'(out_pop);

  // Stage boundary: FIFO storage write (data, not reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_keep[i]) r_mem[r_tail + PW'(w_off[i])] <= w_dec[i];
      end
    end
  end

  // Stage boundary: pointer / count update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + (w_accept ? PW'(w_k) : PW'(0));
      r_count <= r_count + (w_accept ? CW'(w_k) : CW'(0)) - w_pop;
    end
  end

  // Head window; slots beyond the count read as zero so reset shows all-zero.
  always_comb begin
    out_entry = '0;
    out_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i] = (r_count > CW'(i));
      if (out_valid[i]) out_entry[EW*i +: EW] = r_mem[r_head + PW'(i)];
    end
  end

  assign in_ready  = w_ready;
  assign occupancy = r_count;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int TW = 4;
  localparam int DN = 1;
  localparam int EW = 52 + TW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      in_valid;
  logic [32*W-1:0]   in_instr;
  logic [TW*W-1:0]   in_branch_tag;
  logic [W-1:0]      in_macro_start;
  logic [W-1:0]      in_macro_end;
  logic              in_ready;
  logic              flush;
  logic [EW*W-1:0]   out_entry;
  logic [W-1:0]      out_valid;
  logic [1:0]        out_pop;
  logic [3:0]        occupancy;

  int n_vec = 0;
  int n_bad = 0;

  logic [EW-1:0] mq [$];

  decode_queue #(.WIDTH(W), .DEPTH(D), .TAG_W(TW), .DROP_NOOP(DN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_branch_tag(in_branch_tag), .in_macro_start(in_macro_start),
    .in_macro_end(in_macro_end), .in_ready(in_ready), .flush(flush),
    .out_entry(out_entry), .out_valid(out_valid), .out_pop(out_pop),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  alu;
    logic [2:0]  rs;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  tg;
    logic [15:0] imm;
    logic        h1;
    logic        h2;
    logic        ht;
    logic        nop;
  } dec_t;

  // Reference decode, format-driven: pick station/alu and which instruction
  // fields act as sources/destination/immediate, then fill generically.
  function automatic dec_t ref_dec(input logic [31:0] x);
    dec_t d;
    int st, fn;
    bit src_rs, src_rt, dst_rt, dst_rd, use_imm;
    st = 0; fn = 0; src_rs = 0; src_rt = 0; dst_rt = 0; dst_rd = 0; use_imm = 0;
    case (int'(x[31:26]))
      'h09: begin st = 1; fn = 0; src_rs = 1; dst_rt = 1; use_imm = 1; end
      'h0C: begin st = 1; fn = 2; src_rs = 1; dst_rt = 1; use_imm = 1; end
      'h04: begin st = 3; fn = 3; src_rs = 1; src_rt = 1; use_imm = 1; end
      'h23: begin st = 4; fn = 0; src_rs = 1; dst_rt = 1; use_imm = 1; end
      'h2B: begin st = 4; fn = 1; src_rs = 1; src_rt = 1; use_imm = 1; end
      'h0F: begin st = 3; fn = 0; dst_rt = 1; use_imm = 1; end
      'h00: case (int'(x[5:0]))
        'h21: begin st = 1; fn = 0; src_rs = 1; src_rt = 1; dst_rd = 1; end
        'h24: begin st = 1; fn = 1; src_rs = 1; src_rt = 1; dst_rd = 1; end
        'h1A: begin st = 2; fn = 0; src_rs = 1; src_rt = 1; end
        'h10: begin st = 2; fn = 1; dst_rd = 1; end
        'h12: begin st = 2; fn = 2; dst_rd = 1; end
        default: ;
      endcase
      default: ;
    endcase
    d.op  = (st != 0) ? x[31:26] : 6'd0;
    d.alu = 6'(fn);
    d.rs  = 3'(st);
    d.r1  = src_rs ? x[25:21] : 5'd0;
    d.h1  = src_rs;
    d.r2  = src_rt ? x[20:16] : 5'd0;
    d.h2  = src_rt;
    d.tg  = dst_rt ? x[20:16] : (dst_rd ? x[15:11] : 5'd0);
    d.ht  = dst_rt | dst_rd;
    d.imm = use_imm ? x[15:0] : 16'd0;
    d.nop = (st == 0) || (d.ht && d.tg == 5'd0);
    return d;
  endfunction

  function automatic logic [EW-1:0] pack(input dec_t d, input logic [TW-1:0] tag,
                                         input logic ms, input logic me);
    return {d.op, d.alu, d.rs, d.r1, d.r2, d.tg, d.imm, d.h1, d.h2, d.ht, d.nop, tag, ms, me};
  endfunction

  function automatic logic [63:0] fld(input logic [EW-1:0] e, input int lsb, input int w);
    logic [63:0] t;
    t = 64'(e) >> lsb;
    return t & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: updates the expected queue on each clock edge.
  always @(posedge clk or negedge rst_n) begin : model
    int sz, np;
    bit rdy;
    dec_t d;
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      rdy = (D - sz) >= W;
      if (int'(out_pop) > sz) begin
        n_vec++; n_bad++;
        $display("FAIL pop_protocol: out_pop %0d, occupancy %0d", out_pop, sz);
      end
      np = (int'(out_pop) > sz) ? sz : int'(out_pop);
      for (int i = 0; i < np; i++) void'(mq.pop_front());
      if (rdy && in_valid != '0) begin
        for (int i = 0; i < W; i++) begin
          d = ref_dec(in_instr[32*i +: 32]);
          if (in_valid[i] && !(DN != 0 && d.nop))
            mq.push_back(pack(d, in_branch_tag[TW*i +: TW], in_macro_start[i], in_macro_end[i]));
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the model on the falling edge.
  always @(negedge clk) begin : monitor
    logic [W-1:0] ev;
    for (int i = 0; i < W; i++) ev[i] = (i < mq.size());
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'(!flush && (D - mq.size()) >= W));
    for (int i = 0; i < W; i++)
      if (i < mq.size()) chk("slot_entry", 64'(out_entry[EW*i +: EW]), 64'(mq[i]));
  end

  task automatic step(input logic [W-1:0] v, input logic [31:0] a, input logic [31:0] b,
                      input int pop, input logic fl);
    in_valid       = v;
    in_instr       = {b, a};
    in_branch_tag  = (TW*W)'($urandom);
    in_macro_start = W'($urandom);
    in_macro_end   = W'($urandom);
    out_pop        = 2'(pop);
    flush          = fl;
    @(posedge clk); #1;
    in_valid = '0;
    out_pop  = '0;
    flush    = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 12))
      0:  return {6'h09, r[25:0]};
      1:  return {6'h0C, r[25:0]};
      2:  return {6'h04, r[25:0]};
      3:  return {6'h23, r[25:0]};
      4:  return {6'h2B, r[25:0]};
      5:  return {6'h0F, r[25:0]};
      6:  return {6'h00, r[25:6], 6'h21};
      7:  return {6'h00, r[25:6], 6'h24};
      8:  return {6'h00, r[25:6], 6'h1A};
      9:  return {6'h00, r[25:6], 6'h10};
      10: return {6'h00, r[25:6], 6'h12};
      11: return r;
      default: return {6'h09, r[25:21], 5'd0, r[15:0]};
    endcase
  endfunction

  function automatic int pop_lim();
    return (mq.size() < W) ? mq.size() : W;
  endfunction

  localparam logic [31:0] ADDIU = 32'h2401_0005;
  localparam logic [31:0] LUI   = 32'h3C02_1234;
  localparam logic [31:0] ADDU  = 32'h0022_1821;
  localparam logic [31:0] LW    = 32'h8C24_0004;
  localparam logic [31:0] SW    = 32'hAC22_0008;

  initial begin
    logic [EW-1:0] s0, s1;
    in_valid = '0; in_instr = '0; in_branch_tag = '0;
    in_macro_start = '0; in_macro_end = '0; out_pop = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_out_entry", 64'(out_entry[EW-1:0]), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addiu + lui
    step(2'b11, ADDIU, LUI, 0, 1'b0);
    s0 = out_entry[EW-1:0];
    s1 = out_entry[2*EW-1:EW];
    chk("first_out_valid", 64'(out_valid), 64'h3);
    chk("s0_rs", fld(s0, 41, 3), 64'd1);
    chk("s0_reg1", fld(s0, 36, 5), 64'd0);
    chk("s0_target", fld(s0, 26, 5), 64'd1);
    chk("s0_imm", fld(s0, 10, 16), 64'd5);
    chk("s0_alu", fld(s0, 44, 6), 64'd0);
    chk("s0_has_reg1", fld(s0, 9, 1), 64'd1);
    chk("s1_rs", fld(s1, 41, 3), 64'd3);
    chk("s1_target", fld(s1, 26, 5), 64'd2);
    chk("s1_imm", fld(s1, 10, 16), 64'h1234);
    chk("s1_noop", fld(s1, 6, 1), 64'd0);
    chk("first_occ", 64'(occupancy), 64'd2);
    step(2'b00, 0, 0, 2, 1'b0);

    // no-op dropping
    step(2'b11, 32'hFC00_0000, 32'h2000_0000, 0, 1'b0);
    chk("drop_occ", 64'(occupancy), 64'd0);
    step(2'b11, 32'h2400_0005, SW, 0, 1'b0);
    s0 = out_entry[EW-1:0];
    chk("sw_occ", 64'(occupancy), 64'd1);
    chk("sw_rs", fld(s0, 41, 3), 64'd4);
    chk("sw_alu", fld(s0, 44, 6), 64'd1);
    step(2'b00, 0, 0, 1, 1'b0);

    // full / pop / simultaneous push+pop
    repeat (3) step(2'b11, ADDU, LW, 0, 1'b0);
    step(2'b01, ADDU, LW, 0, 1'b0);
    chk("fill7_occ", 64'(occupancy), 64'd7);
    chk("fill7_ready", 64'(in_ready), 64'd0);
    step(2'b11, ADDU, LW, 0, 1'b0);
    chk("full_reject_occ", 64'(occupancy), 64'd7);
    step(2'b00, 0, 0, 2, 1'b0);
    chk("pop2_occ", 64'(occupancy), 64'd5);
    chk("pop2_ready", 64'(in_ready), 64'd1);
    step(2'b11, ADDU, LW, 1, 1'b0);
    chk("pushpop_occ", 64'(occupancy), 64'd6);

    // flush with a bundle present
    step(2'b11, ADDU, LW, 0, 1'b1);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);

    // 20 bundles streaming through with wrap
    for (int n = 0; n < 20; n++) step(2'b11, gen_instr(), gen_instr(), pop_lim(), 1'b0);
    while (mq.size() != 0) step(2'b00, 0, 0, pop_lim(), 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step(W'($urandom), gen_instr(), gen_instr(), $urandom_range(0, pop_lim()),
           ($urandom_range(0, 29) == 0));

    // async reset mid-operation
    step(2'b00, 0, 0, pop_lim(), 1'b1);
    step(2'b11, ADDU, LW, 0, 1'b0);
    step(2'b11, ADDU, LW, 0, 1'b0);
    chk("pre_reset_occ", 64'(occupancy), 64'd4);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_occ", 64'(occupancy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2'b11, ADDIU, LUI, 0, 1'b0);
    chk("post_reset_occ", 64'(occupancy), 64'd2);
    chk("post_reset_s0_target", fld(out_entry[EW-1:0], 26, 5), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
